// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for a single-write-port register file: MEM has priority, ALU gets a
// forced grant after STARVE_LIMIT consecutive losses; also flags read-after-write hazards.
module regfile_wb_arbiter #(
  parameter int unsigned AW           = 5,
  parameter int unsigned DW           = 8,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          mem_req,
  input  logic [AW-1:0] mem_a,
  input  logic [DW-1:0] mem_wd,
  output logic          mem_gnt,
  input  logic          alu_req,
  input  logic [AW-1:0] alu_a,
  input  logic [DW-1:0] alu_wd,
  output logic          alu_gnt,
  output logic [AW-1:0] a3,
  output logic [DW-1:0] wd,
  output logic          we,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          haz1,
  output logic          haz2
);

  localparam logic [2:0] Limit = 3'(STARVE_LIMIT);

  logic [2:0]    starve_q, starve_d;
  logic          force_alu;
  logic [AW-1:0] a3_d;
  logic [DW-1:0] wd_d;
  logic          we_d;
  logic          we_live;

  // Grants are held low through reset so no request is consumed by a write that reset discards.
  always_comb begin
    mem_gnt   = 1'b0;
    alu_gnt   = 1'b0;
    force_alu = alu_req && (starve_q == Limit);
    if (!reset) begin
      if (alu_req && (force_alu || !mem_req)) begin
        alu_gnt = 1'b1;
      end else if (mem_req) begin
        mem_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (alu_gnt || !alu_req) begin
      starve_d = 3'd0;
    end else if (starve_q < Limit) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_comb begin
    a3_d = a3;
    wd_d = wd;
    we_d = 1'b0;
    if (mem_gnt) begin
      a3_d = mem_a;
      wd_d = mem_wd;
      we_d = (mem_a != '0);
    end else if (alu_gnt) begin
      a3_d = alu_a;
      wd_d = alu_wd;
      we_d = (alu_a != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= 3'd0;
      a3       <= '0;
      wd       <= '0;
      we       <= 1'b0;
    end else begin
      starve_q <= starve_d;
      a3       <= a3_d;
      wd       <= wd_d;
      we       <= we_d;
    end
  end

  // A write pending in the output register is discarded by reset, so it stops counting.
  assign we_live = we && !reset;

  assign haz1 = (ra1 != '0) && ((mem_req && (mem_a == ra1)) || (alu_req && (alu_a == ra1)) ||
                                (we_live && (a3 == ra1)));
  assign haz2 = (ra2 != '0) && ((mem_req && (mem_a == ra2)) || (alu_req && (alu_a == ra2)) ||
                                (we_live && (a3 == ra2)));

  grant_onehot_a: assert property (@(posedge clock) !(mem_gnt && alu_gnt));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected register-file writes go into a queue that a
// negedge monitor drains whenever we is high; grants and hazards are checked inline.
module tb_regfile_wb_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mem_req = 1'b0, alu_req = 1'b0;
  logic [4:0] mem_a = '0, alu_a = '0, ra1 = '0, ra2 = '0;
  logic [7:0] mem_wd = '0, alu_wd = '0;
  logic       mem_gnt, alu_gnt, we, haz1, haz2;
  logic [4:0] a3;
  logic [7:0] wd;

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  regfile_wb_arbiter dut (
    .clock  (clock),
    .reset  (reset),
    .mem_req(mem_req),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_gnt(mem_gnt),
    .alu_req(alu_req),
    .alu_a  (alu_a),
    .alu_wd (alu_wd),
    .alu_gnt(alu_gnt),
    .a3     (a3),
    .wd     (wd),
    .we     (we),
    .ra1    (ra1),
    .ra2    (ra2),
    .haz1   (haz1),
    .haz2   (haz2)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Drive one cycle's inputs just after the rising edge, return at the following falling edge.
  task automatic cyc(input logic rst, input logic mr, input logic [4:0] ma, input logic [7:0] md,
                     input logic ar, input logic [4:0] aa, input logic [7:0] ad,
                     input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clock);
    #1;
    reset   = rst;
    mem_req = mr;
    mem_a   = ma;
    mem_wd  = md;
    alu_req = ar;
    alu_a   = aa;
    alu_wd  = ad;
    ra1     = r1;
    ra2     = r2;
    @(negedge clock);
  endtask

  // Scoreboard monitor: every write presented to the register file must be the next expected one.
  always @(negedge clock) begin
    wr_t e;
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got a3=%0d wd=0x%0h required no write", a3, wd);
      end else begin
        e = exp_q.pop_front();
        check("write_a3_wd", {19'd0, a3, wd}, {19'd0, e.a, e.d});
      end
    end
  end

  // Starvation table: MEM streams fresh data while ALU waits; 1 = MEM grant, 2 = ALU grant.
  logic       t_mr[6] = '{1, 1, 1, 1, 1, 0};
  logic [4:0] t_ma[6] = '{10, 11, 12, 13, 13, 13};
  logic [7:0] t_md[6] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h43, 8'h43};
  logic [4:0] t_aa[6] = '{20, 20, 20, 20, 21, 21};
  logic [7:0] t_ad[6] = '{8'h99, 8'h99, 8'h99, 8'h99, 8'h9A, 8'h9A};
  int         t_gn[6] = '{1, 1, 1, 2, 1, 2};

  initial begin
    // Reset with live requests: no grants, hazards from requests only.
    cyc(1, 1, 4, 8'h0A, 1, 6, 8'h66, 4, 6);
    check("rst_mem_gnt", mem_gnt, 0);
    check("rst_alu_gnt", alu_gnt, 0);
    check("rst_haz1_live", haz1, 1);
    check("rst_haz2_live", haz2, 1);
    cyc(1, 1, 4, 8'h0A, 1, 6, 8'h66, 0, 0);
    check("rst_a3", a3, 0);
    check("rst_wd", wd, 0);
    check("rst_we", we, 0);

    // Lone ALU request.
    cyc(0, 0, 0, 8'h00, 1, 5, 8'h3C, 5, 0);
    check("alu_only_gnt", alu_gnt, 1);
    check("alu_only_mem_gnt", mem_gnt, 0);
    check("alu_only_haz1", haz1, 1);
    push(5, 8'h3C);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    check("alu_only_we_hi", we, 1);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    check("alu_only_we_lo", we, 0);

    // Both request: MEM first, ALU next cycle.
    cyc(0, 1, 2, 8'h11, 1, 3, 8'h22, 0, 0);
    check("both_mem_gnt", mem_gnt, 1);
    check("both_alu_gnt", alu_gnt, 0);
    push(2, 8'h11);
    cyc(0, 0, 2, 8'h11, 1, 3, 8'h22, 0, 0);
    check("both2_alu_gnt", alu_gnt, 1);
    check("both2_mem_gnt", mem_gnt, 0);
    push(3, 8'h22);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

    // Starvation: three MEM wins, forced ALU, then MEM priority again.
    for (int i = 0; i < 6; i++) begin
      cyc(0, t_mr[i], t_ma[i], t_md[i], 1, t_aa[i], t_ad[i], 0, 0);
      check($sformatf("starve%0d_mem_gnt", i), mem_gnt, (t_gn[i] == 1) ? 1 : 0);
      check($sformatf("starve%0d_alu_gnt", i), alu_gnt, (t_gn[i] == 2) ? 1 : 0);
      if (t_gn[i] == 1) push(t_ma[i], t_md[i]);
      else push(t_aa[i], t_ad[i]);
    end
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

    // Write to register 0: granted, never enabled.
    cyc(0, 0, 0, 8'h00, 1, 0, 8'hFF, 0, 0);
    check("zero_alu_gnt", alu_gnt, 1);
    check("zero_haz1", haz1, 0);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    check("zero_we", we, 0);
    check("zero_a3", a3, 0);
    check("zero_wd", wd, 8'hFF);

    // Hazard lifetime across grant and write cycles.
    cyc(0, 1, 7, 8'h55, 0, 0, 8'h00, 7, 8);
    check("haz_mem_gnt", mem_gnt, 1);
    check("haz_req_haz1", haz1, 1);
    check("haz_req_haz2", haz2, 0);
    push(7, 8'h55);
    cyc(0, 0, 7, 8'h55, 0, 0, 8'h00, 7, 8);
    check("haz_we_haz1", haz1, 1);
    check("haz_we_haz2", haz2, 0);
    cyc(0, 0, 7, 8'h55, 0, 0, 8'h00, 7, 8);
    check("haz_done_haz1", haz1, 0);
    check("haz_done_haz2", haz2, 0);

    // Reset on the cycle ALU would win after two losses.
    cyc(0, 1, 1, 8'h0A, 1, 6, 8'h66, 0, 0);
    check("rs_mem_gnt0", mem_gnt, 1);
    push(1, 8'h0A);
    cyc(0, 1, 4, 8'h0B, 1, 6, 8'h66, 0, 0);
    check("rs_mem_gnt1", mem_gnt, 1);
    push(4, 8'h0B);
    cyc(1, 0, 4, 8'h0B, 1, 6, 8'h66, 4, 6);
    check("rs_alu_gnt", alu_gnt, 0);
    check("rs_mem_gnt", mem_gnt, 0);
    check("rs_haz1_we_ignored", haz1, 0);
    check("rs_haz2_live", haz2, 1);
    cyc(0, 1, 9, 8'h0C, 1, 6, 8'h66, 0, 0);
    check("rs_after_we", we, 0);
    check("rs_after_a3", a3, 0);
    check("rs_after_wd", wd, 0);
    check("rs_after_mem_gnt", mem_gnt, 1);
    check("rs_after_alu_gnt", alu_gnt, 0);
    push(9, 8'h0C);
    cyc(0, 0, 9, 8'h0C, 1, 6, 8'h66, 0, 0);
    check("rs_alu_wins", alu_gnt, 1);
    push(6, 8'h66);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
